// File: rtl/mem_stage_pkg.sv
// Shared state encoding, default widths and counter sizing for the multi-cycle memory stage.
// The optional alignment check is enabled by defining MEM_STAGE_ALIGN_CHECK_EN.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_REG_W   = 4;
   localparam int DEF_TIMEOUT = 64;
   localparam int DEF_CNT_W   = $clog2(DEF_TIMEOUT + 1);

   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog counter: clears when idle, counts enabled cycles, flags the cycle whose edge reaches LIMIT.
module mem_wait_timer
   import mem_stage_pkg::*;
#(
   parameter int LIMIT = DEF_TIMEOUT,
   parameter int CNT_W = cnt_width(LIMIT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   logic [CNT_W-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_expire = i_enable && (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_stage_mc.sv
// Multi-cycle memory stage: req/ack data-memory access, upstream stall, timeout watchdog, M/W register.
// Define MEM_STAGE_ALIGN_CHECK_EN to trap odd-address loads/stores into the error state.
module mem_stage_mc
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int REG_W   = DEF_REG_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              x_valid,
   input  logic [DATA_W-1:0] x_alu_result,
   input  logic [DATA_W-1:0] x_store_data,
   input  logic [REG_W-1:0]  x_wr_reg,
   input  logic              x_mem_read,
   input  logic              x_mem_write,
   input  logic              x_reg_write,
   input  logic              x_mem_to_reg,
   input  logic              x_halt,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              w_valid,
   output logic              w_reg_write,
   output logic              w_mem_to_reg,
   output logic              w_halt,
   output logic [REG_W-1:0]  w_wr_reg,
   output logic [DATA_W-1:0] w_alu_result,
   output logic [DATA_W-1:0] w_mem_data,
   output logic              mem_err
);

   state_t              r_state;
   logic                r_mem_err;

   logic                r_req_wr;
   logic [DATA_W-1:0]   r_req_alu;
   logic [DATA_W-1:0]   r_req_wdata;
   logic [REG_W-1:0]    r_req_reg;
   logic                r_req_rw;
   logic                r_req_m2r;
   logic                r_req_halt;

   logic                r_w_valid;
   logic                r_w_rw;
   logic                r_w_m2r;
   logic                r_w_halt;
   logic [REG_W-1:0]    r_w_reg;
   logic [DATA_W-1:0]   r_w_alu;
   logic [DATA_W-1:0]   r_w_mdata;

   logic                w_mem_op;
   logic                w_misalign;
   logic                w_expire;
   logic                w_timer_clear;
   logic                w_timer_en;

   logic                w_load;
   logic [DATA_W-1:0]   w_ld_alu;
   logic [REG_W-1:0]    w_ld_reg;
   logic                w_ld_rw;
   logic                w_ld_m2r;
   logic                w_ld_halt;
   logic [DATA_W-1:0]   w_ld_mdata;

   assign w_mem_op = x_valid && (x_mem_read || x_mem_write);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
   assign w_misalign = w_mem_op && x_alu_result[0];
`else
   assign w_misalign = 1'b0;
`endif

   assign w_timer_clear = (r_state != ST_BUSY);
   assign w_timer_en    = (r_state == ST_BUSY) && !mem_ack;

   mem_wait_timer #(
      .LIMIT (TIMEOUT)
   ) u_wait_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_timer_clear),
      .i_enable (w_timer_en),
      .o_expire (w_expire)
   );

   // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
   always_comb begin
      stall      = 1'b0;
      mem_req    = 1'b0;
      mem_wr     = x_mem_write;
      mem_addr   = x_alu_result[ADDR_W-1:0];
      mem_wdata  = x_store_data;
      w_load     = 1'b0;
      w_ld_alu   = x_alu_result;
      w_ld_reg   = x_wr_reg;
      w_ld_rw    = x_reg_write;
      w_ld_m2r   = x_mem_to_reg;
      w_ld_halt  = x_halt;
      w_ld_mdata = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_mem_op) begin
               if (w_misalign) begin
                  stall = 1'b1;
               end else begin
                  mem_req    = 1'b1;
                  stall      = !mem_ack;
                  w_load     = mem_ack;
                  w_ld_mdata = x_mem_write ? '0 : mem_rdata;
               end
            end else begin
               w_load = x_valid;
            end
         end
         ST_BUSY: begin
            // The latched request drives the bus so it stays stable until ack.
            mem_req    = 1'b1;
            mem_wr     = r_req_wr;
            mem_addr   = r_req_alu[ADDR_W-1:0];
            mem_wdata  = r_req_wdata;
            stall      = !mem_ack;
            w_load     = mem_ack;
            w_ld_alu   = r_req_alu;
            w_ld_reg   = r_req_reg;
            w_ld_rw    = r_req_rw;
            w_ld_m2r   = r_req_m2r;
            w_ld_halt  = r_req_halt;
            w_ld_mdata = r_req_wr ? '0 : mem_rdata;
         end
         default: begin
            stall = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_mem_err   <= 1'b0;
         r_req_wr    <= 1'b0;
         r_req_alu   <= '0;
         r_req_wdata <= '0;
         r_req_reg   <= '0;
         r_req_rw    <= 1'b0;
         r_req_m2r   <= 1'b0;
         r_req_halt  <= 1'b0;
         r_w_valid   <= 1'b0;
         r_w_rw      <= 1'b0;
         r_w_m2r     <= 1'b0;
         r_w_halt    <= 1'b0;
         r_w_reg     <= '0;
         r_w_alu     <= '0;
         r_w_mdata   <= '0;
      end else begin
         // Anything other than a completing instruction enters M/W as an all-zero bubble.
         r_w_valid <= w_load;
         r_w_rw    <= w_load && w_ld_rw;
         r_w_m2r   <= w_load && w_ld_m2r;
         r_w_halt  <= w_load && w_ld_halt;
         r_w_reg   <= w_load ? w_ld_reg   : '0;
         r_w_alu   <= w_load ? w_ld_alu   : '0;
         r_w_mdata <= w_load ? w_ld_mdata : '0;
         case (r_state)
            ST_IDLE: begin
               if (w_mem_op) begin
                  if (w_misalign) begin
                     r_state   <= ST_ERR;
                     r_mem_err <= 1'b1;
                  end else if (!mem_ack) begin
                     r_state     <= ST_BUSY;
                     r_req_wr    <= x_mem_write;
                     r_req_alu   <= x_alu_result;
                     r_req_wdata <= x_store_data;
                     r_req_reg   <= x_wr_reg;
                     r_req_rw    <= x_reg_write;
                     r_req_m2r   <= x_mem_to_reg;
                     r_req_halt  <= x_halt;
                  end
               end
            end
            ST_BUSY: begin
               if (mem_ack) begin
                  r_state <= ST_IDLE;
               end else if (w_expire) begin
                  r_state   <= ST_ERR;
                  r_mem_err <= 1'b1;
               end
            end
            default: begin
               r_state   <= ST_ERR;
               r_mem_err <= 1'b1;
            end
         endcase
      end
   end

   assign w_valid      = r_w_valid;
   assign w_reg_write  = r_w_rw;
   assign w_mem_to_reg = r_w_m2r;
   assign w_halt       = r_w_halt;
   assign w_wr_reg     = r_w_reg;
   assign w_alu_result = r_w_alu;
   assign w_mem_data   = r_w_mdata;
   assign mem_err      = r_mem_err;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Self-checking bench for mem_stage_mc: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic with random acks and resets.
module tb_mem_stage_mc;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 16;
   localparam int REG_W   = 4;
   localparam int TIMEOUT = 8;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              x_valid = 1'b0;
   logic [DATA_W-1:0] x_alu_result = '0;
   logic [DATA_W-1:0] x_store_data = '0;
   logic [REG_W-1:0]  x_wr_reg = '0;
   logic              x_mem_read = 1'b0;
   logic              x_mem_write = 1'b0;
   logic              x_reg_write = 1'b0;
   logic              x_mem_to_reg = 1'b0;
   logic              x_halt = 1'b0;
   logic              mem_ack = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              stall, mem_req, mem_wr, mem_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              w_valid, w_reg_write, w_mem_to_reg, w_halt;
   logic [REG_W-1:0]  w_wr_reg;
   logic [DATA_W-1:0] w_alu_result, w_mem_data;

   always #5 clk = ~clk;

   mem_stage_mc #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .REG_W   (REG_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .x_valid      (x_valid),
      .x_alu_result (x_alu_result),
      .x_store_data (x_store_data),
      .x_wr_reg     (x_wr_reg),
      .x_mem_read   (x_mem_read),
      .x_mem_write  (x_mem_write),
      .x_reg_write  (x_reg_write),
      .x_mem_to_reg (x_mem_to_reg),
      .x_halt       (x_halt),
      .stall        (stall),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .w_valid      (w_valid),
      .w_reg_write  (w_reg_write),
      .w_mem_to_reg (w_mem_to_reg),
      .w_halt       (w_halt),
      .w_wr_reg     (w_wr_reg),
      .w_alu_result (w_alu_result),
      .w_mem_data   (w_mem_data),
      .mem_err      (mem_err)
   );

   typedef struct packed {
      logic              valid;
      logic              rw;
      logic              m2r;
      logic              halt;
      logic [REG_W-1:0]  wr_reg;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] mdata;
   } wb_t;

   typedef struct packed {
      logic              is_write;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] wdata;
      logic [REG_W-1:0]  wr_reg;
      logic              rw;
      logic              m2r;
      logic              halt;
   } req_t;

   // Reference model: at most one outstanding request, a wait count, a sticky error flag.
   req_t pend[$];
   int   m_wait = 0;
   bit   m_err  = 1'b0;
   bit   m_live = 1'b0;
   wb_t  exp_wb = '0;

   int n_vec = 0;
   int n_mis = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit misaligned(input logic [DATA_W-1:0] a);
      return ALIGN_EN && a[0];
   endfunction

   function automatic req_t from_x();
      req_t r;
      r.is_write = x_mem_write;
      r.alu      = x_alu_result;
      r.wdata    = x_store_data;
      r.wr_reg   = x_wr_reg;
      r.rw       = x_reg_write;
      r.m2r      = x_mem_to_reg;
      r.halt     = x_halt;
      return r;
   endfunction

   function automatic wb_t retire(input req_t r, input logic [DATA_W-1:0] rdata);
      wb_t w;
      w.valid  = 1'b1;
      w.rw     = r.rw;
      w.m2r    = r.m2r;
      w.halt   = r.halt;
      w.wr_reg = r.wr_reg;
      w.alu    = r.alu;
      w.mdata  = r.is_write ? '0 : rdata;
      return w;
   endfunction

   always @(posedge clk) begin : model
      req_t r;
      r = from_x();
      if (!rst_n) begin
         pend.delete();
         m_wait = 0;
         m_err  = 1'b0;
         exp_wb = '0;
         m_live = 1'b1;
      end else if (m_err) begin
         exp_wb = '0;
      end else if (pend.size() != 0) begin
         if (mem_ack) begin
            exp_wb = retire(pend[0], mem_rdata);
            pend.delete();
         end else begin
            exp_wb = '0;
            m_wait++;
            if (m_wait == TIMEOUT) begin
               m_err = 1'b1;
               pend.delete();
            end
         end
      end else if (x_valid && (x_mem_read || x_mem_write)) begin
         if (misaligned(x_alu_result)) begin
            m_err  = 1'b1;
            exp_wb = '0;
         end else if (mem_ack) begin
            exp_wb = retire(r, mem_rdata);
         end else begin
            pend.push_back(r);
            m_wait = 0;
            exp_wb = '0;
         end
      end else if (x_valid) begin
         exp_wb = retire(r, '0);
      end else begin
         exp_wb = '0;
      end
   end

   always @(negedge clk) begin : compare
      logic              e_req, e_stall, e_wr;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wdata;
      if (m_live) begin
         e_req   = 1'b0;
         e_stall = 1'b0;
         e_wr    = 1'b0;
         e_addr  = '0;
         e_wdata = '0;
         if (m_err) begin
            e_stall = 1'b1;
         end else if (pend.size() != 0) begin
            e_req   = 1'b1;
            e_stall = !mem_ack;
            e_wr    = pend[0].is_write;
            e_addr  = pend[0].alu[ADDR_W-1:0];
            e_wdata = pend[0].wdata;
         end else if (x_valid && (x_mem_read || x_mem_write)) begin
            if (misaligned(x_alu_result)) begin
               e_stall = 1'b1;
            end else begin
               e_req   = 1'b1;
               e_stall = !mem_ack;
               e_wr    = x_mem_write;
               e_addr  = x_alu_result[ADDR_W-1:0];
               e_wdata = x_store_data;
            end
         end
         check("stall", 64'(stall), 64'(e_stall));
         check("mem_req", 64'(mem_req), 64'(e_req));
         if (e_req) begin
            check("mem_addr", 64'(mem_addr), 64'(e_addr));
            check("mem_wr", 64'(mem_wr), 64'(e_wr));
            check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
         end
         check("mem_err", 64'(mem_err), 64'(m_err));
         check("w_bundle",
               64'({w_valid, w_reg_write, w_mem_to_reg, w_halt, w_wr_reg, w_alu_result, w_mem_data}),
               64'(exp_wb));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_x(input logic v, input logic rd, input logic wr,
                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] sd,
                        input logic [REG_W-1:0] rg, input logic rw, input logic m2r,
                        input logic hlt);
      x_valid      = v;
      x_mem_read   = rd;
      x_mem_write  = wr;
      x_alu_result = alu;
      x_store_data = sd;
      x_wr_reg     = rg;
      x_reg_write  = rw;
      x_mem_to_reg = m2r;
      x_halt       = hlt;
   endtask

   task automatic idle_x();
      set_x(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_x();
      mem_ack = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin : driver
      logic       hold;
      logic [1:0] op;
      idle_x();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("rst_w_valid", 64'(w_valid), 64'h0);
      check("rst_w_alu", 64'(w_alu_result), 64'h0);
      check("rst_stall", 64'(stall), 64'h0);
      check("rst_mem_req", 64'(mem_req), 64'h0);
      check("rst_mem_err", 64'(mem_err), 64'h0);

      // ALU instruction passes through in one cycle with no stall.
      set_x(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0, 4'd3, 1'b1, 1'b0, 1'b0);
      #1 check("alu_stall", 64'(stall), 64'h0);
      tick();
      check("alu_w_alu", 64'(w_alu_result), 64'h1234);
      check("alu_w_reg", 64'(w_wr_reg), 64'h3);
      check("alu_w_valid", 64'(w_valid), 64'h1);
      check("alu_w_rw", 64'(w_reg_write), 64'h1);

      // Load with three wait cycles.
      set_x(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 4'd5, 1'b1, 1'b1, 1'b0);
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("ld_stall", 64'(stall), 64'h1);
         check("ld_addr", 64'(mem_addr), 64'h0040);
         tick();
      end
      mem_ack   = 1'b1;
      mem_rdata = 16'hBEEF;
      #1 check("ld_ack_stall", 64'(stall), 64'h0);
      tick();
      check("ld_w_mdata", 64'(w_mem_data), 64'hBEEF);
      check("ld_w_m2r", 64'(w_mem_to_reg), 64'h1);
      check("ld_w_reg", 64'(w_wr_reg), 64'h5);

      // Zero-wait store.
      set_x(1'b1, 1'b0, 1'b1, 16'h0010, 16'h00AA, 4'd0, 1'b0, 1'b0, 1'b0);
      mem_ack = 1'b1;
      #1;
      check("st_wr", 64'(mem_wr), 64'h1);
      check("st_wdata", 64'(mem_wdata), 64'h00AA);
      check("st_stall", 64'(stall), 64'h0);
      tick();
      check("st_w_mdata", 64'(w_mem_data), 64'h0);
      check("st_w_valid", 64'(w_valid), 64'h1);
      mem_ack = 1'b0;

      // Reset while a load is outstanding, then a late ack.
      set_x(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0, 4'd7, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      do_reset();
      mem_ack   = 1'b1;
      mem_rdata = 16'h1111;
      #1;
      check("rstb_req", 64'(mem_req), 64'h0);
      check("rstb_stall", 64'(stall), 64'h0);
      tick();
      check("rstb_w_valid", 64'(w_valid), 64'h0);
      check("rstb_w_mdata", 64'(w_mem_data), 64'h0);
      mem_ack = 1'b0;

      // Watchdog: the request never completes.
      set_x(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0, 4'd2, 1'b1, 1'b1, 1'b0);
      tick();
      for (int k = 1; k < TIMEOUT; k++) begin
         tick();
         check("to_err_early", 64'(mem_err), 64'h0);
      end
      tick();
      check("to_err", 64'(mem_err), 64'h1);
      check("to_req", 64'(mem_req), 64'h0);
      check("to_stall", 64'(stall), 64'h1);
      do_reset();

      // Odd address.
      set_x(1'b1, 1'b1, 1'b0, 16'h0041, 16'h0, 4'd4, 1'b1, 1'b1, 1'b0);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      #1 check("al_req", 64'(mem_req), 64'h0);
      tick();
      check("al_err", 64'(mem_err), 64'h1);
      check("al_w_valid", 64'(w_valid), 64'h0);
      do_reset();
`else
      mem_ack   = 1'b1;
      mem_rdata = 16'h5A5A;
      #1 check("al_addr", 64'(mem_addr), 64'h0041);
      tick();
      check("al_w_mdata", 64'(w_mem_data), 64'h5A5A);
      mem_ack = 1'b0;
`endif

      // Randomized traffic; X/M stays frozen while the stage is stalled.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         hold = m_err || (pend.size() != 0);
         if ((m_err && $urandom_range(1, 0) == 0) || $urandom_range(99, 0) == 0) begin
            rst_n = 1'b0;
         end else begin
            rst_n = 1'b1;
         end
         if (!hold) begin
            op = 2'($urandom_range(3, 0));
            x_valid      = ($urandom_range(9, 0) != 0);
            x_mem_read   = (op == 2'd1) || (op == 2'd3);
            x_mem_write  = (op == 2'd2) || (op == 2'd3);
            x_alu_result = DATA_W'($urandom);
            if ($urandom_range(7, 0) != 0) x_alu_result[0] = 1'b0;
            x_store_data = DATA_W'($urandom);
            x_wr_reg     = REG_W'($urandom);
            x_reg_write  = 1'($urandom);
            x_mem_to_reg = 1'($urandom);
            x_halt       = ($urandom_range(15, 0) == 0);
         end
         if (pend.size() != 0 || (x_valid && (x_mem_read || x_mem_write))) begin
            mem_ack = ($urandom_range(2, 0) == 0);
         end else begin
            mem_ack = ($urandom_range(4, 0) == 0);
         end
         mem_rdata = DATA_W'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
